// File: rtl/tcb_lib_irw2crw.sv
// rtl/tcb_lib_irw2crw.sv - merges independent read/write TCB channels onto one combined read/write manager port
module tcb_lib_irw2crw #(
  parameter int    DLY = 1,
  parameter string ARB = "RR",
  parameter int    AW  = 32,
  parameter int    DW  = 32,
  parameter int    BW  = DW/8
) (
  input  logic          clk,
  input  logic          rst,
  // read channel subordinate (read manager connects here)
  input  logic          rdc_vld_i,
  input  logic [AW-1:0] rdc_adr_i,
  input  logic [BW-1:0] rdc_ben_i,
  output logic          rdc_rdy_o,
  output logic [DW-1:0] rdc_rdt_o,
  output logic          rdc_err_o,
  // write channel subordinate (write manager connects here)
  input  logic          wrc_vld_i,
  input  logic [AW-1:0] wrc_adr_i,
  input  logic [BW-1:0] wrc_ben_i,
  input  logic [DW-1:0] wrc_wdt_i,
  output logic          wrc_rdy_o,
  output logic [DW-1:0] wrc_rdt_o,
  output logic          wrc_err_o,
  // combined read/write manager
  output logic          crw_vld_o,
  output logic          crw_ren_o,
  output logic          crw_wen_o,
  output logic [AW-1:0] crw_adr_o,
  output logic [BW-1:0] crw_ben_o,
  output logic [DW-1:0] crw_wdt_o,
  input  logic          crw_rdy_i,
  input  logic [DW-1:0] crw_rdt_i,
  input  logic          crw_err_i
);

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } gnt_t;

  localparam bit ARB_RD = (ARB == "RD");
  localparam bit ARB_WR = (ARB == "WR");

  generate
    if (!(ARB == "RR" || ARB == "RD" || ARB == "WR")) begin : g_bad_arb
      $error("tcb_lib_irw2crw: ARB must be RR, RD or WR");
    end
    if (DLY < 0) begin : g_bad_dly
      $error("tcb_lib_irw2crw: DLY must be non-negative");
    end
  endgenerate

  gnt_t gnt;
  logic lck_q, lck_d;
  gnt_t lck_gnt_q, lck_gnt_d;
  gnt_t ptr_q, ptr_d;
  logic trn;
  logic rte_rd, rte_wr;

  // arbitration: a locked grant is held until its transfer, otherwise the policy decides
  always_comb begin
    gnt = GNT_RD;
    if (lck_q) begin
      gnt = lck_gnt_q;
    end else if (rdc_vld_i && !wrc_vld_i) begin
      gnt = GNT_RD;
    end else if (wrc_vld_i && !rdc_vld_i) begin
      gnt = GNT_WR;
    end else if (rdc_vld_i && wrc_vld_i) begin
      if (ARB_RD)      gnt = GNT_RD;
      else if (ARB_WR) gnt = GNT_WR;
      else             gnt = (ptr_q == GNT_RD) ? GNT_WR : GNT_RD;
    end
  end

  // request path: granted channel drives the combined bus, wen/ren forced by grant
  always_comb begin
    crw_vld_o = rdc_vld_i | wrc_vld_i;
    crw_ren_o = (gnt == GNT_RD);
    crw_wen_o = (gnt == GNT_WR);
    crw_adr_o = (gnt == GNT_WR) ? wrc_adr_i : rdc_adr_i;
    crw_ben_o = (gnt == GNT_WR) ? wrc_ben_i : rdc_ben_i;
    crw_wdt_o = (gnt == GNT_WR) ? wrc_wdt_i : '0;
    rdc_rdy_o = (gnt == GNT_RD) & crw_rdy_i;
    wrc_rdy_o = (gnt == GNT_WR) & crw_rdy_i;
    trn       = crw_vld_o & crw_rdy_i;
  end

  // lock a stalled request onto its grant; remember the last winner for round-robin
  always_comb begin
    lck_d     = lck_q;
    lck_gnt_d = lck_gnt_q;
    ptr_d     = ptr_q;
    if (trn) begin
      lck_d = 1'b0;
      ptr_d = gnt;
    end else if (crw_vld_o) begin
      lck_d     = 1'b1;
      lck_gnt_d = gnt;
    end
  end

  // arbitration state registers; ptr resets to WR so RD wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      lck_q     <= 1'b0;
      lck_gnt_q <= GNT_RD;
      ptr_q     <= GNT_WR;
    end else begin
      lck_q     <= lck_d;
      lck_gnt_q <= lck_gnt_d;
      ptr_q     <= ptr_d;
    end
  end

  generate
    if (DLY > 0) begin : g_dly
      logic [1:0] rte_q [DLY];

      // age each transfer's destination {rd, wr} so it selects the response DLY cycles later
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) rte_q[i] <= 2'b00;
        end else begin
          rte_q[0] <= {trn & (gnt == GNT_RD), trn & (gnt == GNT_WR)};
          for (int i = 1; i < DLY; i++) rte_q[i] <= rte_q[i-1];
        end
      end

      assign rte_rd = rte_q[DLY-1][1];
      assign rte_wr = rte_q[DLY-1][0];
    end else begin : g_comb
      assign rte_rd = trn & (gnt == GNT_RD);
      assign rte_wr = trn & (gnt == GNT_WR);
    end
  endgenerate

  // response path: only the issuing channel sees the response, the other reads zero
  always_comb begin
    rdc_rdt_o = rte_rd ? crw_rdt_i : '0;
    rdc_err_o = rte_rd ? crw_err_i : 1'b0;
    wrc_rdt_o = rte_wr ? crw_rdt_i : '0;
    wrc_err_o = rte_wr ? crw_err_i : 1'b0;
  end

endmodule

// File: tb/tb_tcb_lib_irw2crw.sv
// tb/tb_tcb_lib_irw2crw.sv - randomized bench for tcb_lib_irw2crw against a transaction-level model
module tb_tcb_lib_irw2crw;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int NDUT = 3;
  localparam int NCYC = 2400;
  // per instance: response delay and policy (0 = RR, 1 = RD, 2 = WR)
  localparam int DLYS [NDUT] = '{1, 2, 0};
  localparam int ARBC [NDUT] = '{0, 2, 1};

  logic clk = 1'b0;
  logic rst;

  logic          rd_vld [NDUT];
  logic [AW-1:0] rd_adr [NDUT];
  logic [BW-1:0] rd_ben [NDUT];
  logic          rd_rdy [NDUT];
  logic [DW-1:0] rd_rdt [NDUT];
  logic          rd_err [NDUT];
  logic          wr_vld [NDUT];
  logic [AW-1:0] wr_adr [NDUT];
  logic [BW-1:0] wr_ben [NDUT];
  logic [DW-1:0] wr_wdt [NDUT];
  logic          wr_rdy [NDUT];
  logic [DW-1:0] wr_rdt [NDUT];
  logic          wr_err [NDUT];
  logic          crw_vld [NDUT];
  logic          crw_ren [NDUT];
  logic          crw_wen [NDUT];
  logic [AW-1:0] crw_adr [NDUT];
  logic [BW-1:0] crw_ben [NDUT];
  logic [DW-1:0] crw_wdt [NDUT];
  logic          crw_rdy [NDUT];
  logic [DW-1:0] crw_rdt [NDUT];
  logic          crw_err [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    tcb_lib_irw2crw #(
      .DLY (DLYS[g]),
      .ARB (g == 0 ? "RR" : (g == 1 ? "WR" : "RD")),
      .AW  (AW),
      .DW  (DW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .rdc_vld_i (rd_vld[g]),
      .rdc_adr_i (rd_adr[g]),
      .rdc_ben_i (rd_ben[g]),
      .rdc_rdy_o (rd_rdy[g]),
      .rdc_rdt_o (rd_rdt[g]),
      .rdc_err_o (rd_err[g]),
      .wrc_vld_i (wr_vld[g]),
      .wrc_adr_i (wr_adr[g]),
      .wrc_ben_i (wr_ben[g]),
      .wrc_wdt_i (wr_wdt[g]),
      .wrc_rdy_o (wr_rdy[g]),
      .wrc_rdt_o (wr_rdt[g]),
      .wrc_err_o (wr_err[g]),
      .crw_vld_o (crw_vld[g]),
      .crw_ren_o (crw_ren[g]),
      .crw_wen_o (crw_wen[g]),
      .crw_adr_o (crw_adr[g]),
      .crw_ben_o (crw_ben[g]),
      .crw_wdt_o (crw_wdt[g]),
      .crw_rdy_i (crw_rdy[g]),
      .crw_rdt_i (crw_rdt[g]),
      .crw_err_i (crw_err[g])
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // model state: held = channel stuck waiting for acceptance (-1 none, 0 RD, 1 WR),
  // last = channel of the most recent transfer, hist = destination of each cycle's transfer
  int held [NDUT];
  int last [NDUT];
  int hist [NDUT][NCYC];
  bit rd_keep [NDUT];
  bit wr_keep [NDUT];

  function automatic int mgnt(int k, logic rv, logic wv);
    if (held[k] >= 0) return held[k];
    if (rv && !wv) return 0;
    if (wv && !rv) return 1;
    if (rv && wv) begin
      if (ARBC[k] == 1) return 0;
      if (ARBC[k] == 2) return 1;
      return (last[k] == 0) ? 1 : 0;
    end
    return 0;
  endfunction

  initial begin
    int pv, pr, g, dst, src;
    bit trn, prev_rst;
    string s;

    rst = 1'b1;
    prev_rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      held[k] = -1;
      last[k] = 1;
      rd_keep[k] = 1'b0;
      wr_keep[k] = 1'b0;
      rd_vld[k] = 1'b0; rd_adr[k] = '0; rd_ben[k] = '0;
      wr_vld[k] = 1'b0; wr_adr[k] = '0; wr_ben[k] = '0; wr_wdt[k] = '0;
      crw_rdy[k] = 1'b0; crw_rdt[k] = '0; crw_err[k] = 1'b0;
      for (int c = 0; c < NCYC; c++) hist[k][c] = 0;
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (c < 6)         begin pv = 100; pr = 100; end
      else if (c < 1000) begin pv = 60;  pr = 70;  end
      else if (c < 1600) begin pv = 80;  pr = 30;  end
      else               begin pv = 90;  pr = 100; end
      rst = (c < 2) || (c > 20 && c < 1000 && $urandom_range(0, 99) == 0);
      for (int k = 0; k < NDUT; k++) begin
        if (prev_rst || !rd_keep[k]) begin
          rd_vld[k] = ($urandom_range(0, 99) < pv);
          rd_adr[k] = AW'($urandom);
          rd_ben[k] = BW'($urandom);
        end
        if (prev_rst || !wr_keep[k]) begin
          wr_vld[k] = ($urandom_range(0, 99) < pv);
          wr_adr[k] = AW'($urandom);
          wr_ben[k] = BW'($urandom);
          wr_wdt[k] = $urandom;
        end
        if (rst) begin
          rd_vld[k] = 1'b0;
          wr_vld[k] = 1'b0;
        end
        crw_rdy[k] = ($urandom_range(0, 99) < pr);
        crw_rdt[k] = $urandom;
        crw_err[k] = 1'($urandom_range(0, 1));
      end

      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        g   = mgnt(k, rd_vld[k], wr_vld[k]);
        trn = (rd_vld[k] | wr_vld[k]) & crw_rdy[k];
        hist[k][c] = trn ? (g == 1 ? 2 : 1) : 0;
        src = c - DLYS[k];
        dst = (src >= 0) ? hist[k][src] : 0;
        if (c >= 2) begin
          s = $sformatf("u%0d c%0d ", k, c);
          chk({s, "crw_vld"}, crw_vld[k], rd_vld[k] | wr_vld[k]);
          if (rd_vld[k] | wr_vld[k]) begin
            chk({s, "crw_wen"}, crw_wen[k], g == 1);
            chk({s, "crw_ren"}, crw_ren[k], g == 0);
            chk({s, "crw_adr"}, crw_adr[k], g == 1 ? wr_adr[k] : rd_adr[k]);
            chk({s, "crw_ben"}, crw_ben[k], g == 1 ? wr_ben[k] : rd_ben[k]);
            if (g == 1) chk({s, "crw_wdt"}, crw_wdt[k], wr_wdt[k]);
          end
          chk({s, "rdc_rdy"}, rd_rdy[k], (g == 0) & crw_rdy[k]);
          chk({s, "wrc_rdy"}, wr_rdy[k], (g == 1) & crw_rdy[k]);
          chk({s, "rdc_rdt"}, rd_rdt[k], dst == 1 ? crw_rdt[k] : 32'h0);
          chk({s, "rdc_err"}, rd_err[k], dst == 1 ? crw_err[k] : 1'b0);
          chk({s, "wrc_rdt"}, wr_rdt[k], dst == 2 ? crw_rdt[k] : 32'h0);
          chk({s, "wrc_err"}, wr_err[k], dst == 2 ? crw_err[k] : 1'b0);
          // first four tied cycles after reset: RR alternates from RD, WR-priority always WR, RD-priority always RD
          if (c < 6) begin
            if (k == 0) chk({s, "rr_seq_wen"}, crw_wen[k], (c - 2) % 2 == 1);
            if (k == 1) chk({s, "wr_pri_wen"}, crw_wen[k], 1'b1);
            if (k == 2) chk({s, "rd_pri_wen"}, crw_wen[k], 1'b0);
          end
        end
        // advance the model to the coming edge
        if (rst) begin
          held[k] = -1;
          last[k] = 1;
          for (int j = c - DLYS[k] + 1; j <= c; j++) if (j >= 0) hist[k][j] = 0;
        end else if (trn) begin
          held[k] = -1;
          last[k] = g;
        end else if (rd_vld[k] | wr_vld[k]) begin
          held[k] = g;
        end
        rd_keep[k] = rd_vld[k] & !(trn & (g == 0)) & !rst;
        wr_keep[k] = wr_vld[k] & !(trn & (g == 1)) & !rst;
      end
      prev_rst = rst;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
